// File: rtl/ioctl_upload_server_if.sv
// Bus bundle between hps_io (ioctl upload side), the game core pause handshake
// and the core RAM read port. The server takes the slave view.
interface ioctl_upload_server_if #(parameter int ADDR_W = 10);
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_req;
  logic              pause_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              busy;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    output ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    input  ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy
  );
endinterface

// File: rtl/ioctl_upload_server.sv
// Serves HPS upload reads from core RAM: pauses the CPU, fetches one byte per
// ioctl_rd and stalls the HPS with ioctl_wait until the byte is registered.
module ioctl_upload_server #(
  parameter int ADDR_W   = 10,
  parameter int DUMP_LEN = 256,
  parameter int RAM_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  ioctl_upload_server_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;

  localparam logic [24:0] DUMP_C = 25'(DUMP_LEN);
  localparam logic [1:0]  LAT_C  = 2'(RAM_LAT);

  state_t            state_q;
  logic [7:0]        din_q;
  logic              wait_q, pause_q, rd_q, busy_q, pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [24:0]       pend_addr_q;
  logic [1:0]        cnt_q;

  logic [24:0] req_addr_c;
  logic        req_oor_c, take_rd_c;

  // A new strobe is honoured only while not stalling; otherwise it is a protocol violation.
  always_comb begin
    req_addr_c = pend_q ? pend_addr_q : bus.ioctl_addr;
    req_oor_c  = (req_addr_c >= DUMP_C);
    take_rd_c  = bus.ioctl_rd && !wait_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      din_q       <= 8'h00;
      wait_q      <= 1'b0;
      pause_q     <= 1'b0;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      pend_addr_q <= '0;
      cnt_q       <= '0;
    end else begin
      rd_q <= 1'b0;
      if (state_q != IDLE && !bus.ioctl_upload) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        pause_q <= 1'b0;
        wait_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (take_rd_c) begin
              pend_q      <= 1'b1;
              pend_addr_q <= bus.ioctl_addr;
              wait_q      <= 1'b1;
            end
            if (bus.ioctl_upload) begin
              state_q <= PAUSE;
              busy_q  <= 1'b1;
              pause_q <= 1'b1;
            end
          end
          PAUSE: begin
            if (take_rd_c) begin
              pend_q      <= 1'b1;
              pend_addr_q <= bus.ioctl_addr;
              wait_q      <= 1'b1;
            end
            if (bus.pause_ack) state_q <= READY;
          end
          READY: begin
            if (!bus.pause_ack) begin
              state_q <= PAUSE;
              if (take_rd_c) begin
                pend_q      <= 1'b1;
                pend_addr_q <= bus.ioctl_addr;
                wait_q      <= 1'b1;
              end
            end else if (pend_q || take_rd_c) begin
              wait_q <= 1'b1;
              if (req_oor_c) begin
                din_q  <= 8'hFF;
                pend_q <= 1'b0;
              end else begin
                // Request stays pending through the fetch so a lost ack can replay it.
                state_q     <= FETCH;
                rd_q        <= 1'b1;
                addr_q      <= req_addr_c[ADDR_W-1:0];
                cnt_q       <= LAT_C;
                pend_q      <= 1'b1;
                pend_addr_q <= req_addr_c;
              end
            end else begin
              wait_q <= 1'b0;
            end
          end
          FETCH: begin
            if (!bus.pause_ack) begin
              state_q <= PAUSE;
            end else if (cnt_q == 2'd0) begin
              din_q   <= bus.ram_q;
              wait_q  <= 1'b0;
              pend_q  <= 1'b0;
              state_q <= READY;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.pause_req  = pause_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_rd     = rd_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ioctl_upload_server.sv
// Bench for ioctl_upload_server: RAM_LAT=1 instance for the main flows,
// RAM_LAT=3 instance for the pause_ack fault/restart case.
module tb_ioctl_upload_server;
  localparam int DUMP = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ioctl_upload_server_if #(.ADDR_W(10)) b1 ();
  ioctl_upload_server_if #(.ADDR_W(10)) b3 ();

  ioctl_upload_server #(.ADDR_W(10), .DUMP_LEN(DUMP), .RAM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  ioctl_upload_server #(.ADDR_W(10), .DUMP_LEN(DUMP), .RAM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  logic [7:0] mem [1024];
  logic [7:0] p1;
  logic [7:0] p3 [3];
  int rdcnt1 = 0;
  int rdcnt3 = 0;

  // RAM models: data valid exactly RAM_LAT cycles after ram_rd, junk otherwise
  always @(posedge clk) begin
    p1    <= b1.ram_rd ? mem[b1.ram_addr] : 8'hEE;
    p3[0] <= b3.ram_rd ? mem[b3.ram_addr] : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (b1.ram_rd) rdcnt1 <= rdcnt1 + 1;
    if (b3.ram_rd) rdcnt3 <= rdcnt3 + 1;
  end
  assign b1.ram_q = p1;
  assign b3.ram_q = p3[2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] last_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One HPS read on the RAM_LAT=1 instance; expectations from the address map.
  task automatic rd1(input logic [24:0] a, input string tag);
    int n, r0;
    logic inr;
    logic [7:0] exp;
    inr = (a < 25'(DUMP));
    exp = inr ? mem[a[9:0]] : 8'hFF;
    n = 0;
    while (b1.ioctl_wait && n < 50) begin step(); n++; end
    r0 = rdcnt1;
    b1.ioctl_rd = 1'b1; b1.ioctl_addr = a;
    step();
    b1.ioctl_rd = 1'b0; b1.ioctl_addr = 25'($urandom);
    chk({tag, ".ram_rd"}, 32'(b1.ram_rd), 32'(inr));
    if (inr) chk({tag, ".ram_addr"}, 32'(b1.ram_addr), 32'(a[9:0]));
    n = 0;
    while (b1.ioctl_wait && n < 50) begin n++; step(); end
    chk({tag, ".wait_cycles"}, 32'(n), inr ? 32'd2 : 32'd1);
    chk({tag, ".din"}, 32'(b1.ioctl_din), 32'(exp));
    chk({tag, ".rd_pulses"}, 32'(rdcnt1 - r0), 32'(inr));
    last_din = exp;
  endtask

  initial begin
    int r0, whigh, chg, rds;
    logic seen_low;
    logic [7:0] prev;
    logic [24:0] ra;
    for (int i = 0; i < 1024; i++) mem[i] = (i < DUMP) ? (8'(i) ^ 8'hA5) : 8'($urandom);
    b1.ioctl_upload = 0; b1.ioctl_rd = 0; b1.ioctl_addr = 0; b1.pause_ack = 0;
    b3.ioctl_upload = 0; b3.ioctl_rd = 0; b3.ioctl_addr = 0; b3.pause_ack = 0;
    last_din = 8'h00;

    repeat (3) step();
    chk("rst.din", 32'(b1.ioctl_din), 0);
    chk("rst.wait", 32'(b1.ioctl_wait), 0);
    chk("rst.pause_req", 32'(b1.pause_req), 0);
    chk("rst.ram_rd", 32'(b1.ram_rd), 0);
    chk("rst.ram_addr", 32'(b1.ram_addr), 0);
    chk("rst.busy", 32'(b1.busy), 0);
    reset = 1'b0;
    step();
    chk("idle.busy", 32'(b1.busy), 0);

    // Upload with delayed ack, then the first read
    b1.ioctl_upload = 1'b1;
    step();
    chk("pause.req", 32'(b1.pause_req), 1);
    chk("pause.busy", 32'(b1.busy), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pause.hold", 32'({b1.pause_req, b1.ioctl_wait}), 32'b10);
    end
    b1.pause_ack = 1'b1;
    step();
    mem[10'h10] = 8'h5A;
    rd1(25'h10, "first");
    mem[10'h10] = 8'h10 ^ 8'hA5;

    // Full sequential dump
    r0 = rdcnt1;
    for (int i = 0; i < DUMP; i++) rd1(25'(i), "seq");
    chk("seq.total_rd", 32'(rdcnt1 - r0), 32'd256);

    // Out-of-range addresses, including high bits over an in-range low part
    rd1(25'h100, "oor100");
    rd1(25'h1FFFFFF, "oor_max");
    rd1(25'h1000010, "oor_hi");
    rd1(25'h0FF, "last_in");

    // Random mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 25'($urandom);
        1:       ra = 25'($urandom_range(256, 1023));
        default: ra = 25'($urandom_range(0, 255));
      endcase
      rd1(ra, "rand");
    end

    // Abort the cycle after ram_rd
    b1.ioctl_rd = 1'b1; b1.ioctl_addr = 25'h20;
    step();
    b1.ioctl_rd = 1'b0;
    chk("abort.ram_rd", 32'(b1.ram_rd), 1);
    b1.ioctl_upload = 1'b0;
    step();
    chk("abort.wait", 32'(b1.ioctl_wait), 0);
    chk("abort.pause_req", 32'(b1.pause_req), 0);
    chk("abort.busy", 32'(b1.busy), 0);
    chk("abort.din", 32'(b1.ioctl_din), 32'(last_din));
    repeat (3) step();
    chk("abort.din_hold", 32'(b1.ioctl_din), 32'(last_din));

    // Reset mid-fetch, then a clean restart
    b1.ioctl_upload = 1'b1;
    step(); step();
    b1.ioctl_rd = 1'b1; b1.ioctl_addr = 25'h40;
    step();
    b1.ioctl_rd = 1'b0;
    chk("rstf.in_fetch", 32'(b1.ram_rd), 1);
    reset = 1'b1;
    step();
    chk("rstf.outs", 32'({b1.ioctl_din, b1.ioctl_wait, b1.pause_req, b1.ram_rd, b1.busy}), 0);
    chk("rstf.ram_addr", 32'(b1.ram_addr), 0);
    reset = 1'b0;
    step();
    chk("rstf.pause", 32'({b1.pause_req, b1.busy, b1.ioctl_wait}), 32'b110);
    step();
    rd1(25'h41, "rstf.read");

    // RAM_LAT=3 with pause_ack lost mid-fetch
    b3.ioctl_upload = 1'b1; b3.pause_ack = 1'b1;
    repeat (3) step();
    r0 = rdcnt3;
    prev = b3.ioctl_din;
    b3.ioctl_rd = 1'b1; b3.ioctl_addr = 25'h33;
    whigh = 0; chg = 0; seen_low = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      b3.ioctl_rd = 1'b0;
      if (c == 2) b3.pause_ack = 1'b0;
      if (c == 6) b3.pause_ack = 1'b1;
      if (b3.ioctl_wait && !seen_low) whigh++;
      if (!b3.ioctl_wait) seen_low = 1'b1;
      if (b3.ioctl_din !== prev) chg++;
      prev = b3.ioctl_din;
    end
    rds = rdcnt3 - r0;
    chk("lat3.wait_high", 32'(whigh), 32'd11);
    chk("lat3.din_updates", 32'(chg), 32'd1);
    chk("lat3.rd_pulses", 32'(rds), 32'd2);
    chk("lat3.din", 32'(b3.ioctl_din), 32'(8'h33 ^ 8'hA5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ioctl_upload_server.md
Name: ioctl_upload_server

Overview:
Responder side of the HPS ioctl transfer. Where the ROM path only accepts bytes the HPS writes in, this block serves bytes the HPS reads out during an upload, for example a high-score or NVRAM dump from game work RAM. It pauses the game CPU through a request/acknowledge pair, fetches each requested byte from a synchronous RAM read port, and holds the HPS off with ioctl_wait until the byte is valid. It sits in the emu top between hps_io and the game core's RAM.

Parameters:
ADDR_W, 10, width of ram_addr; the RAM holds 2^ADDR_W bytes.
DUMP_LEN, 256, number of servable bytes; must be ≤ 2^ADDR_W. Higher addresses read 8'hFF.
RAM_LAT, 1, cycles from ram_rd to valid ram_q; legal range 1..3.

Ports:
clk  in  1  system clock (clk_sys).
reset  in  1  synchronous, active-high.
ioctl_upload  in  1  upload session active (level).
ioctl_rd  in  1  one-cycle read strobe; ioctl_addr is valid in the same cycle.
ioctl_addr  in  25  byte address requested by HPS.
ioctl_din  out  8  read data to HPS.
ioctl_wait  out  1  stall to HPS; HPS issues no new ioctl_rd while high.
pause_req  out  1  request to halt the game CPU.
pause_ack  in  1  CPU halted; core RAM port free.
ram_addr  out  ADDR_W  RAM read address.
ram_rd  out  1  one-cycle RAM read strobe.
ram_q  in  8  RAM read data, valid RAM_LAT cycles after ram_rd.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (any state, any cycle): state=IDLE; ioctl_din=0, ioctl_wait=0, pause_req=0, ram_rd=0, ram_addr=0, busy=0; pending request and latency counter cleared.
- IDLE: stays while ioctl_upload=0. On ioctl_upload=1, moves to PAUSE next cycle.
- PAUSE: pause_req=1. Moves to READY on the first cycle pause_ack=1.
- READY: pause_req=1. Waits for a request (pending latch or ioctl_rd).
  - Address < DUMP_LEN: moves to FETCH.
  - Address ≥ DUMP_LEN: no RAM access; ioctl_din=8'hFF next cycle; ioctl_wait=1 for exactly 1 cycle.
- FETCH: on entry cycle, ram_rd=1 for 1 cycle and ram_addr=addr[ADDR_W-1:0]; latency counter loads RAM_LAT. After RAM_LAT cycles, ram_q is registered into ioctl_din and state returns to READY.
- Timing for rd sampled at cycle N in READY (in range): ram_rd at N+1; ioctl_wait high over N+1..N+1+RAM_LAT; ioctl_din updated and ioctl_wait low from N+2+RAM_LAT. With RAM_LAT=1: wait high at N+1 and N+2; data valid at N+3.
- ioctl_din holds its last value between reads.
- ioctl_rd in IDLE or PAUSE: address latched as a pending request; ioctl_wait rises next cycle and stays high until that read completes after the ack.
- Only one pending request is kept. An ioctl_rd while ioctl_wait=1 is a protocol violation; it is ignored and the original request completes.
- ioctl_upload falling in any non-IDLE state: abort. Next cycle state=IDLE, pause_req=0, ioctl_wait=0, pending request discarded, ioctl_din unchanged. A RAM read in flight is discarded.
- pause_ack dropping while in READY or FETCH: treated as a core fault; state returns to PAUSE. An in-flight fetch is restarted once pause_ack returns; ioctl_wait stays high meanwhile.
- Address width: bits above ADDR_W are used only for the DUMP_LEN compare (full 25-bit compare), never for ram_addr.
- ioctl_upload rising together with ioctl_rd in the same cycle: the rd is latched as pending.

Test Plan:
- Reset mid-FETCH (RAM_LAT=1) -> next cycle all outputs 0 and state IDLE; a later upload starts cleanly from PAUSE.
- Upload=1, pause_ack delayed 5 cycles, then ioctl_rd with addr 0x000010 and RAM[0x10]=0x5A -> pause_req high from cycle 1; ram_rd with ram_addr=0x010 one cycle after entering READY; ioctl_din=0x5A and ioctl_wait low 3 cycles after the rd is taken.
- Sequential reads of addr 0..255 against a RAM model holding addr^0xA5, each rd issued only when wait is low -> every byte matches; exactly 256 ram_rd pulses.
- ioctl_rd addr 0x000100 and 0x1FFFFFF with DUMP_LEN=256 -> no ram_rd; ioctl_din=0xFF; ioctl_wait high for exactly 1 cycle.
- ioctl_upload dropped the cycle after ram_rd -> ioctl_wait=0 and pause_req=0 next cycle; ioctl_din unchanged; state IDLE.
- RAM_LAT=3, rd at cycle N with pause_ack deasserted at N+2, reasserted at N+6 -> fetch restarts; a single ioctl_din update with correct data; ioctl_wait continuous high until the update.
